sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-port round-robin arbiter sharing the single sdram controller word interface (addr/din/dout/wmask/valid/ready) between two picorv32-style memory requesters, e.g. CPU on port 0 and a DMA/video fetch engine on port 1.
- Runs the controller's four-phase handshake for the granted port: raise valid, wait ready high, drop valid, wait ready low.
- Returns a one-cycle ready pulse to the granted requester.
- A watchdog aborts transactions the controller never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles allowed in each wait state before abort; 0 disables the watchdog.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  port 0 request; held until m0_ready
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_wstrb  in  4  port 0 byte strobes; 0 = read
- m0_ready  out  1  port 0 completion pulse
- m0_rdata  out  32  port 0 read data, valid with m0_ready
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as port 0, for port 1
- sdram_addr  out  25  controller byte address
- sdram_din  out  32  controller write data
- sdram_wmask  out  4  controller byte mask
- sdram_valid  out  1  controller request
- sdram_dout  in  32  controller read data
- sdram_ready  in  1  controller acknowledge
- grant  out  2  one-hot owner of the current transaction; 00 when idle
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, resetn=0): all outputs 0, state IDLE, watchdog counter 0, last_grant = port 1, so port 0 wins the first tie. Deasserting sdram_valid mid-transaction is the legal abort for the controller.
- All outputs are registered.
- States: IDLE, REQ, REL, DONE.
- IDLE:
  - Accepts a request only when sdram_ready=0.
  - Candidate ports are those with mX_valid=1.
  - If both request: FIXED_PRIO=1 picks port 0; otherwise pick the port != last_grant.
  - On grant, at that edge:
    - sdram_addr <= {mX_addr[24:2], 2'b00}
    - sdram_din <= mX_wdata
    - sdram_wmask <= mX_wstrb
    - sdram_valid <= 1
    - grant set; last_grant updated; counter cleared; go to REQ.
- REQ: wait for sdram_ready=1. Then:
  - Capture sdram_dout into the granted port's rdata register (reads only; writes leave rdata unchanged).
  - sdram_valid <= 0, sdram_wmask <= 0, counter cleared; go to REL.
- REL: wait for sdram_ready=0, then go to DONE with the granted mX_ready <= 1.
- DONE:
  - mX_ready is high for exactly this cycle.
  - Next edge: mX_ready <= 0, grant <= 00, back to IDLE.
  - The requester drops mX_valid at the edge that samples ready, so that port is not regranted in the following IDLE unless it raises a new request.
- Latency with an instant controller (ready rises the cycle after valid and falls the cycle after valid drops):
  - valid sampled at edge 0, sdram_valid high after edge 0.
  - REL entered at edge 2, DONE at edge 3, mX_ready high cycle 3–4.
  - Minimum request-to-ready is 4 cycles; back-to-back grants are spaced 5 cycles apart.
- Watchdog:
  - Counter increments each cycle in REQ and REL, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES (when non-zero): timeout_err pulses 1 cycle, sdram_valid <= 0, sdram_wmask <= 0, granted rdata <= 32'hDEAD_BEEF, go to DONE.
  - The requester is always released and never hangs.
- The non-granted port's mX_ready stays 0 throughout; its request waits in place, with no starvation under round-robin.
- The non-granted port's rdata register holds its last value.
- A request arriving while the other port is in REQ/REL/DONE is served at the next IDLE.
- Address bits [31:25] are ignored; decode happens upstream.

Test Plan:
- Single write: m0 write addr 0x4000_0010, wdata 0x1234_5678, wstrb 0xF, model acks after 3 cycles -> sdram_addr = 0x0000010, din = 0x1234_5678, wmask = 0xF during REQ; exactly one m0_ready pulse; m1_ready stays 0.
- Single read: m1 read addr 0x4000_0104, model returns 0xCAFE_F00D -> sdram_wmask = 0; m1_rdata = 0xCAFE_F00D with m1_ready; grant = 10 during the transaction.
- Contention: both ports valid continuously for 6 transactions, FIXED_PRIO = 0 -> grant order 0,1,0,1,0,1. With FIXED_PRIO = 1 -> port 0 served first whenever both are pending.
- Timeout: TIMEOUT_CYCLES = 16, model never raises ready -> timeout_err pulse on cycle 17; m0_ready pulse with rdata 0xDEAD_BEEF; sdram_valid = 0; next request proceeds normally.
- Async reset mid-transaction: assert resetn = 0 while in REQ, between clock edges -> sdram_valid, grant and all ready outputs go 0 immediately. After release, the first tie goes to port 0.
- Ready stuck high at IDLE: hold sdram_ready = 1 with m0_valid = 1 -> no grant and sdram_valid stays 0 until ready falls.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter in front of one sdram word controller.
// Latency: request to mX_ready is 4 cycles minimum; back-to-back grants 5 cycles apart.
// Backpressure: a losing requester holds mX_valid until served; a stuck controller is aborted by the watchdog.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   mX_valid/addr/wdata/wstrb         requester X inputs (wstrb == 0 means read)
//   mX_ready/rdata                    requester X one-cycle completion pulse and read data
//   sdram_addr/din/wmask/valid        controller request side (four-phase handshake)
//   sdram_dout/ready                  controller response side
//   grant                             one-hot owner of the current transaction, 00 when idle
//   timeout_err                       one-cycle pulse when the watchdog aborts a transaction
module sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [24:0] sdram_addr,
  output logic [31:0] sdram_din,
  output logic [3:0]  sdram_wmask,
  output logic        sdram_valid,
  input  logic [31:0] sdram_dout,
  input  logic        sdram_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // 1 = port 1 was granted last
  logic          sel;                // port picked in IDLE, 1 = port 1
  logic          abort;
  logic          wd_hit;

  logic [24:0] sdram_addr_d;
  logic [31:0] sdram_din_d;
  logic [3:0]  sdram_wmask_d;
  logic        sdram_valid_d;
  logic [1:0]  grant_d;
  logic        timeout_err_d;
  logic        m0_ready_d, m1_ready_d;
  logic [31:0] m0_rdata_d, m1_rdata_d;

  // Word-aligned address bits above 24 are decoded upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:25], m0_addr[1:0], m1_addr[31:25], m1_addr[1:0]};

  // A zero timeout disables the watchdog entirely.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      sdram_wmask <= '0;
      sdram_valid <= 1'b0;
      grant       <= 2'b00;
      timeout_err <= 1'b0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sdram_addr  <= sdram_addr_d;
      sdram_din   <= sdram_din_d;
      sdram_wmask <= sdram_wmask_d;
      sdram_valid <= sdram_valid_d;
      grant       <= grant_d;
      timeout_err <= timeout_err_d;
      m0_ready    <= m0_ready_d;
      m1_ready    <= m1_ready_d;
      m0_rdata    <= m0_rdata_d;
      m1_rdata    <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    sdram_addr_d  = sdram_addr;
    sdram_din_d   = sdram_din;
    sdram_wmask_d = sdram_wmask;
    sdram_valid_d = sdram_valid;
    grant_d       = grant;
    timeout_err_d = 1'b0;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    m0_rdata_d    = m0_rdata;
    m1_rdata_d    = m1_rdata;
    sel           = 1'b0;
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        // A controller still holding ready from the previous handshake must
        // finish its release before a new request is launched.
        if (!sdram_ready && (m0_valid || m1_valid)) begin
          if (m0_valid && m1_valid) sel = FIXED_PRIO ? 1'b0 : ~last_q;
          else                      sel = m1_valid;
          sdram_addr_d  = sel ? {m1_addr[24:2], 2'b00} : {m0_addr[24:2], 2'b00};
          sdram_din_d   = sel ? m1_wdata : m0_wdata;
          sdram_wmask_d = sel ? m1_wstrb : m0_wstrb;
          sdram_valid_d = 1'b1;
          grant_d       = sel ? 2'b10 : 2'b01;
          last_d        = sel;
          cnt_d         = '0;
          state_d       = REQ;
        end
      end
      REQ: begin
        if (sdram_ready) begin
          // wmask still holds the request strobes here, so zero means read.
          if (sdram_wmask == 4'b0000) begin
            if (grant[1]) m1_rdata_d = sdram_dout;
            else          m0_rdata_d = sdram_dout;
          end
          sdram_valid_d = 1'b0;
          sdram_wmask_d = 4'b0000;
          cnt_d         = '0;
          state_d       = REL;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else if (cnt_q != TMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REL: begin
        if (!sdram_ready) begin
          m0_ready_d = grant[0];
          m1_ready_d = grant[1];
          state_d    = DONE;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else if (cnt_q != TMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog abort: release the requester with a recognisable poison word.
    if (abort) begin
      timeout_err_d = 1'b1;
      sdram_valid_d = 1'b0;
      sdram_wmask_d = 4'b0000;
      if (grant[1]) m1_rdata_d = ABORT_DATA;
      else          m0_rdata_d = ABORT_DATA;
      m0_ready_d    = grant[0];
      m1_ready_d    = grant[1];
      state_d       = DONE;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a round-robin instance (a_*) and a
// fixed-priority instance (b_*) share the requester inputs; each has its own
// controller model that pulses ready for one cycle after a programmable delay.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] rd_data;
  logic        rdy0, rdy1;

  logic        a_m0_ready, a_m1_ready, a_valid, a_to;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_din;
  logic [24:0] a_addr;
  logic [3:0]  a_wmask;
  logic [1:0]  a_grant;

  logic        b_m0_ready, b_m1_ready, b_valid, b_to;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_din;
  logic [24:0] b_addr;
  logic [3:0]  b_wmask;
  logic [1:0]  b_grant;

  sdram_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(a_m0_ready), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
    .sdram_addr(a_addr), .sdram_din(a_din), .sdram_wmask(a_wmask), .sdram_valid(a_valid),
    .sdram_dout(rd_data), .sdram_ready(rdy0), .grant(a_grant), .timeout_err(a_to)
  );

  sdram_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .sdram_addr(b_addr), .sdram_din(b_din), .sdram_wmask(b_wmask), .sdram_valid(b_valid),
    .sdram_dout(rd_data), .sdram_ready(rdy1), .grant(b_grant), .timeout_err(b_to)
  );

  // Controller model
  int ack_delay;
  bit ack_en;
  bit force_rdy;
  int c0, c1;
  bit k0, k1;

  task automatic mdl_step(input logic v, inout logic r, inout int cnt, inout bit acked);
    if (!resetn) begin
      r = 1'b0; cnt = 0; acked = 1'b0;
    end else if (force_rdy) begin
      r = 1'b1;
    end else if (r) begin
      r = 1'b0;
    end else if (!v) begin
      cnt = 0; acked = 1'b0;
    end else if (ack_en && !acked) begin
      if (cnt >= ack_delay) begin r = 1'b1; acked = 1'b1; end
      else cnt++;
    end
  endtask

  initial begin
    rdy0 = 1'b0; rdy1 = 1'b0; c0 = 0; c1 = 0; k0 = 1'b0; k1 = 1'b0;
    forever begin
      @(negedge clk);
      mdl_step(a_valid, rdy0, c0, k0);
      mdl_step(b_valid, rdy1, c1, k1);
    end
  end

  // Pulse counters and grant-start log
  int cyc = 0;
  int m0_n = 0, m1_n = 0, to_n = 0;
  logic [1:0] gq0[$], gq1[$];
  int gt0[$];
  logic [1:0] pg0 = 2'b00, pg1 = 2'b00;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (a_m0_ready) m0_n++;
      if (a_m1_ready) m1_n++;
      if (a_to) to_n++;
      if (a_grant != 2'b00 && pg0 == 2'b00) begin gq0.push_back(a_grant); gt0.push_back(cyc); end
      if (b_grant != 2'b00 && pg1 == 2'b00) gq1.push_back(b_grant);
      pg0 = a_grant;
      pg1 = b_grant;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  int vectors = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int port, input int maxc, output int took);
    took = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (((port == 0) ? a_m0_ready : a_m1_ready) === 1'b1) begin
        took = i;
        break;
      end
    end
  endtask

  initial begin
    int took, base0, base1, base_to, done;
    logic [1:0] g;
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    rd_data = '0; ack_delay = 1; ack_en = 1'b1; force_rdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_m0_ready", 32'(a_m0_ready), 32'h0);
    chk("rst_m1_ready", 32'(a_m1_ready), 32'h0);
    chk("rst_timeout", 32'(a_to), 32'h0);
    chk("rst_addr", 32'(a_addr), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Single write on port 0, controller acks after 3 cycles
    ack_delay = 3;
    base0 = m0_n; base1 = m1_n;
    m0_addr = 32'h4000_0010; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF; m0_valid = 1'b1;
    @(negedge clk);
    chk("wr_grant", 32'(a_grant), 32'h1);
    chk("wr_valid", 32'(a_valid), 32'h1);
    chk("wr_addr", 32'(a_addr), 32'h0000010);
    chk("wr_din", a_din, 32'h1234_5678);
    chk("wr_wmask", 32'(a_wmask), 32'hF);
    wait_rdy(0, 10, took);
    chk("wr_latency", 32'(took), 32'd5);
    m0_valid = 1'b0;
    @(negedge clk);
    chk("wr_grant_clr", 32'(a_grant), 32'h0);
    chk("wr_ready_clr", 32'(a_m0_ready), 32'h0);
    repeat (4) @(negedge clk);
    chk("wr_pulses", 32'(m0_n - base0), 32'd1);
    chk("wr_m1_quiet", 32'(m1_n - base1), 32'd0);

    // Single read on port 1, immediate controller
    ack_delay = 1;
    rd_data = 32'hCAFE_F00D;
    m1_addr = 32'h4000_0104; m1_wdata = 32'hFFFF_FFFF; m1_wstrb = 4'h0; m1_valid = 1'b1;
    @(negedge clk);
    chk("rd_grant", 32'(a_grant), 32'h2);
    chk("rd_addr", 32'(a_addr), 32'h0000104);
    chk("rd_wmask", 32'(a_wmask), 32'h0);
    wait_rdy(1, 10, took);
    chk("rd_latency", 32'(took), 32'd3);
    chk("rd_rdata", a_m1_rdata, 32'hCAFE_F00D);
    chk("rd_grant_done", 32'(a_grant), 32'h2);
    chk("rd_m0_rdata_held", a_m0_rdata, 32'h0);
    m1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Contention: both ports request continuously for six transactions
    gq0.delete(); gq1.delete(); gt0.delete();
    rd_data = 32'h5555_AAAA;
    m0_addr = 32'h0000_0020; m0_wstrb = 4'h3;
    m1_addr = 32'h0000_0030; m1_wstrb = 4'h0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_m0_ready || a_m1_ready) begin
        done++;
        if (done == 6) break;
      end
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    chk("rr_done", 32'(done), 32'd6);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      g = (i < gq0.size()) ? gq0[i] : 2'bxx;
      chk($sformatf("rr_grant%0d", i), 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
      g = (i < gq1.size()) ? gq1[i] : 2'bxx;
      chk($sformatf("fp_grant%0d", i), 32'(g), 32'h1);
    end
    chk("rr_spacing", (gt0.size() >= 2) ? 32'(gt0[1] - gt0[0]) : 32'hFFFF_FFFF, 32'd5);

    // Watchdog: controller never acknowledges
    ack_en = 1'b0;
    @(negedge clk);
    base_to = to_n;
    m0_addr = 32'h0000_0040; m0_wstrb = 4'h0; m0_valid = 1'b1;
    @(negedge clk);
    chk("to_grant", 32'(a_grant), 32'h1);
    repeat (16) @(negedge clk);
    chk("to_early", 32'(a_to), 32'h0);
    chk("to_still_valid", 32'(a_valid), 32'h1);
    @(negedge clk);
    chk("to_pulse", 32'(a_to), 32'h1);
    chk("to_m0_ready", 32'(a_m0_ready), 32'h1);
    chk("to_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    chk("to_valid_drop", 32'(a_valid), 32'h0);
    m0_valid = 1'b0;
    @(negedge clk);
    chk("to_clear", 32'(a_to), 32'h0);
    chk("to_ready_clr", 32'(a_m0_ready), 32'h0);
    chk("to_count", 32'(to_n - base_to), 32'd1);
    ack_en = 1'b1;
    rd_data = 32'h1111_2222;
    @(negedge clk);
    m0_addr = 32'h0000_0044; m0_valid = 1'b1;
    @(negedge clk);
    wait_rdy(0, 10, took);
    chk("post_to_latency", 32'(took), 32'd3);
    chk("post_to_rdata", a_m0_rdata, 32'h1111_2222);
    m0_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in REQ
    ack_en = 1'b0;
    @(negedge clk);
    m0_addr = 32'h0000_0048; m0_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_in_req", 32'(a_valid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_valid", 32'(a_valid), 32'h0);
    chk("ar_grant", 32'(a_grant), 32'h0);
    chk("ar_m0_ready", 32'(a_m0_ready), 32'h0);
    chk("ar_m1_ready", 32'(a_m1_ready), 32'h0);
    chk("ar_rdata", a_m0_rdata, 32'h0);
    m0_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    m0_addr = 32'h0000_0050; m1_addr = 32'h0000_0060;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    @(negedge clk);
    chk("ar_first_tie", 32'(a_grant), 32'h1);
    wait_rdy(0, 10, took);
    chk("ar_m0_latency", 32'(took), 32'd3);
    m0_valid = 1'b0;
    wait_rdy(1, 12, took);
    chk("ar_m1_latency", 32'(took), 32'd5);
    m1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Controller ready stuck high while idle
    #2 force_rdy = 1'b1;
    repeat (2) @(negedge clk);
    m0_addr = 32'h0000_0070; m0_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stk_grant", 32'(a_grant), 32'h0);
    chk("stk_valid", 32'(a_valid), 32'h0);
    #2 force_rdy = 1'b0;
    took = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (a_grant == 2'b01) begin took = i; break; end
    end
    chk("stk_grant_after", 32'(took), 32'd2);
    chk("stk_valid_after", 32'(a_valid), 32'h1);
    wait_rdy(0, 10, took);
    chk("stk_latency", 32'(took), 32'd3);
    m0_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
